lpc_io_arbiter: RTL

Shares the LPC peripheral's single I/O datapath between NUM_CLIENTS register-window clients. It decodes each host I/O cycle's address against per-client windows and drives the peripheral's address-hit and read-data inputs. It forwards write data as single-cycle strobes, waits for client acknowledge, and substitutes 0xFF on timeout. It sits between the LPC peripheral FSM and the POST-code, TPM and misc-register clients.

---
 rtl/lpc_arb_pkg.sv | 29 ++
 rtl/lpc_win_decode.sv | 31 +++
 rtl/lpc_io_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lpc_arb_pkg.sv
// Shared types and helpers for the LPC I/O arbiter: FSM encoding, default
// read value and the address-window compare.
package lpc_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] DEFAULT_RDATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // A set mask bit means that address bit takes part in the compare.
  function automatic logic win_match(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] mask,
    input logic              en
  );
    return en & (((addr ^ base) & mask) == '0);
  endfunction

endpackage

// File: rtl/lpc_win_decode.sv
// Combinational window decode: per-client match followed by a fixed-priority
// (lowest index wins) one-hot select.
module lpc_win_decode
  import lpc_arb_pkg::*;
#(
  parameter int unsigned                  NUM_CLIENTS = 4,
  parameter logic [NUM_CLIENTS*ADDR_W-1:0] WIN_BASE    = {16'h0000, 16'h0060, 16'h0400, 16'h0080},
  parameter logic [NUM_CLIENTS*ADDR_W-1:0] WIN_MASK    = {16'hFFFF, 16'hFFF0, 16'hFF00, 16'hFFFF}
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [NUM_CLIENTS-1:0] i_en,
  output logic [NUM_CLIENTS-1:0] o_sel,
  output logic                   o_valid
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_sel   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (!w_found && win_match(i_addr, WIN_BASE[ADDR_W*k +: ADDR_W],
                                WIN_MASK[ADDR_W*k +: ADDR_W], i_en[k])) begin
        o_sel[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/lpc_io_arbiter.sv
// Shares the LPC peripheral I/O datapath between register-window clients:
// decode, single-cycle strobe, wait for ack (0xFF on timeout), hold until release.
module lpc_io_arbiter
  import lpc_arb_pkg::*;
#(
  parameter int unsigned                  NUM_CLIENTS = 4,
  // Client 0 occupies the rightmost (least significant) entry.
  parameter logic [NUM_CLIENTS*ADDR_W-1:0] WIN_BASE    = {16'h0000, 16'h0060, 16'h0400, 16'h0080},
  parameter logic [NUM_CLIENTS*ADDR_W-1:0] WIN_MASK    = {16'hFFFF, 16'hFFF0, 16'hFF00, 16'hFFFF},
  parameter int unsigned                  TIMEOUT     = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          lframe_i,
  input  logic [ADDR_W-1:0]             lpc_addr_i,
  input  logic [DATA_W-1:0]             lpc_data_in_i,
  input  logic                          io_rden_i,
  input  logic                          io_wren_i,
  output logic                          addr_hit_o,
  output logic [DATA_W-1:0]             din_o,
  output logic [NUM_CLIENTS-1:0]        cl_rd_o,
  output logic [NUM_CLIENTS-1:0]        cl_wr_o,
  output logic [ADDR_W-1:0]             cl_addr_o,
  output logic [DATA_W-1:0]             cl_wdata_o,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_rdata_i,
  input  logic [NUM_CLIENTS-1:0]        cl_ack_i,
  input  logic [NUM_CLIENTS-1:0]        cl_en_i,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              timeout_cnt_o
);

  state_e                 r_state, w_state_nxt;
  logic                   r_req_d;
  logic                   r_is_wr, w_is_wr_nxt;
  logic [NUM_CLIENTS-1:0] r_sel, w_sel_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_addr_hit, w_addr_hit_nxt;
  logic [DATA_W-1:0]      r_din, w_din_nxt;
  logic [NUM_CLIENTS-1:0] r_cl_rd, w_cl_rd_nxt;
  logic [NUM_CLIENTS-1:0] r_cl_wr, w_cl_wr_nxt;
  logic [ADDR_W-1:0]      r_cl_addr, w_cl_addr_nxt;
  logic [DATA_W-1:0]      r_cl_wdata, w_cl_wdata_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [CNT_W-1:0]       r_tcnt, w_tcnt_nxt;

  logic                   w_start;
  logic [NUM_CLIENTS-1:0] w_dec_sel;
  logic                   w_dec_valid;
  logic                   w_ack;
  logic [DATA_W-1:0]      w_rdata;

  lpc_win_decode #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .WIN_BASE    (WIN_BASE),
    .WIN_MASK    (WIN_MASK)
  ) u_win_decode (
    .i_addr  (r_cl_addr),
    .i_en    (cl_en_i),
    .o_sel   (w_dec_sel),
    .o_valid (w_dec_valid)
  );

  assign w_start = (io_rden_i | io_wren_i) & ~r_req_d;
  assign w_ack   = |(cl_ack_i & r_sel);

  // Read data of the selected client (r_sel is one-hot or zero).
  always_comb begin
    w_rdata = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (r_sel[k]) w_rdata = cl_rdata_i[DATA_W*k +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_is_wr_nxt    = r_is_wr;
    w_sel_nxt      = r_sel;
    w_cnt_nxt      = r_cnt;
    w_addr_hit_nxt = r_addr_hit;
    w_din_nxt      = r_din;
    w_cl_rd_nxt    = '0;
    w_cl_wr_nxt    = '0;
    w_cl_addr_nxt  = r_cl_addr;
    w_cl_wdata_nxt = r_cl_wdata;
    w_tcnt_nxt     = r_tcnt;

    if (r_state != ST_IDLE && !lframe_i) begin
      w_state_nxt    = ST_IDLE;
      w_addr_hit_nxt = 1'b0;
      w_din_nxt      = DEFAULT_RDATA;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_state_nxt    = ST_DECODE;
            w_cl_addr_nxt  = lpc_addr_i;
            w_cl_wdata_nxt = lpc_data_in_i;
            w_is_wr_nxt    = io_wren_i & ~io_rden_i;
          end
        end
        ST_DECODE: begin
          if (w_dec_valid) begin
            w_state_nxt = ST_STROBE;
            w_sel_nxt   = w_dec_sel;
            if (r_is_wr) w_cl_wr_nxt = w_dec_sel;
            else         w_cl_rd_nxt = w_dec_sel;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_STROBE: begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
        ST_WAIT: begin
          if (w_ack) begin
            w_state_nxt    = ST_HOLD;
            w_addr_hit_nxt = 1'b1;
            if (!r_is_wr) w_din_nxt = w_rdata;
          end else if (r_cnt + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
            w_state_nxt    = ST_HOLD;
            w_addr_hit_nxt = 1'b1;
            w_din_nxt      = DEFAULT_RDATA;
            if (r_tcnt != '1) w_tcnt_nxt = r_tcnt + CNT_W'(1);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!io_rden_i && !io_wren_i) begin
            w_state_nxt    = ST_IDLE;
            w_addr_hit_nxt = 1'b0;
            w_din_nxt      = DEFAULT_RDATA;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_addr_hit_nxt = 1'b0;
          w_din_nxt      = DEFAULT_RDATA;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_req_d    <= 1'b0;
      r_is_wr    <= 1'b0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_addr_hit <= 1'b0;
      r_din      <= DEFAULT_RDATA;
      r_cl_rd    <= '0;
      r_cl_wr    <= '0;
      r_cl_addr  <= '0;
      r_cl_wdata <= '0;
      r_busy     <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_d    <= io_rden_i | io_wren_i;
      r_is_wr    <= w_is_wr_nxt;
      r_sel      <= w_sel_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_hit <= w_addr_hit_nxt;
      r_din      <= w_din_nxt;
      r_cl_rd    <= w_cl_rd_nxt;
      r_cl_wr    <= w_cl_wr_nxt;
      r_cl_addr  <= w_cl_addr_nxt;
      r_cl_wdata <= w_cl_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_tcnt     <= w_tcnt_nxt;
    end
  end

  assign addr_hit_o    = r_addr_hit;
  assign din_o         = r_din;
  assign cl_rd_o       = r_cl_rd;
  assign cl_wr_o       = r_cl_wr;
  assign cl_addr_o     = r_cl_addr;
  assign cl_wdata_o    = r_cl_wdata;
  assign busy_o        = r_busy;
  assign timeout_cnt_o = r_tcnt;

endmodule
